// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses 0xA5 frames into 19-bit words and writes them to instruction memory.
// A write strobe follows each word's last byte by one cycle; rx_ready is always high (full-rate input).
module imem_loader #(
  parameter int ADDR_W         = 11,
  parameter int BASE_ADDR      = 0,
  parameter int DEPTH          = 2048,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLD_ON_RESET  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [18:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [7:0]        word_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic HOLD_INIT = (HOLD_ON_RESET != 0);

  typedef enum logic [3:0] {
    S_IDLE, S_COUNT, S_B0, S_B1, S_B2, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        n_reg, n_nxt;
  logic [2:0]        b0_reg, b0_nxt;
  logic [7:0]        b1_reg, b1_nxt;
  logic [7:0]        csum, csum_nxt;
  logic [TW-1:0]     tmo, tmo_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [18:0]       wdata_nxt;
  logic              hold_nxt, done_nxt, error_nxt;
  logic [7:0]        wc_nxt;
  logic              accept, active;

  assign rx_ready = 1'b1;
  assign accept   = rx_valid;
  assign active   = (state == S_COUNT) || (state == S_B0) || (state == S_B1) ||
                    (state == S_B2) || (state == S_CSUM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      n_reg      <= 8'd0;
      b0_reg     <= 3'd0;
      b1_reg     <= 8'd0;
      csum       <= 8'd0;
      tmo        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= 19'd0;
      cpu_hold   <= HOLD_INIT;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= 8'd0;
    end else begin
      state      <= state_nxt;
      n_reg      <= n_nxt;
      b0_reg     <= b0_nxt;
      b1_reg     <= b1_nxt;
      csum       <= csum_nxt;
      tmo        <= tmo_nxt;
      imem_we    <= we_nxt;
      imem_addr  <= addr_nxt;
      imem_wdata <= wdata_nxt;
      cpu_hold   <= hold_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      word_count <= wc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    n_nxt     = n_reg;
    b0_nxt    = b0_reg;
    b1_nxt    = b1_reg;
    csum_nxt  = csum;
    we_nxt    = 1'b0;
    addr_nxt  = imem_we ? imem_addr + ADDR_W'(1) : imem_addr;
    wdata_nxt = imem_wdata;
    hold_nxt  = cpu_hold;
    done_nxt  = done;
    error_nxt = error;
    wc_nxt    = word_count;
    tmo_nxt   = (active && !accept) ? tmo + TW'(1) : '0;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept && rx_data == 8'hA5) begin
          hold_nxt  = 1'b1;
          done_nxt  = 1'b0;
          error_nxt = 1'b0;
          wc_nxt    = 8'd0;
          csum_nxt  = 8'd0;
          addr_nxt  = BASE;
          state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (accept) begin
          n_nxt    = rx_data;
          csum_nxt = rx_data;
          // Range is checked once here so the address can never wrap later.
          if (rx_data == 8'd0 || (BASE_ADDR + int'(rx_data)) > DEPTH)
            state_nxt = S_ERR;
          else
            state_nxt = S_B0;
        end
      end
      S_B0: begin
        if (accept) begin
          if (rx_data[7:3] != 5'd0) begin
            state_nxt = S_ERR;
          end else begin
            b0_nxt    = rx_data[2:0];
            csum_nxt  = csum ^ rx_data;
            state_nxt = S_B1;
          end
        end
      end
      S_B1: begin
        if (accept) begin
          b1_nxt    = rx_data;
          csum_nxt  = csum ^ rx_data;
          state_nxt = S_B2;
        end
      end
      S_B2: begin
        if (accept) begin
          csum_nxt  = csum ^ rx_data;
          we_nxt    = 1'b1;
          wdata_nxt = {b0_reg, b1_reg, rx_data};
          wc_nxt    = word_count + 8'd1;
          state_nxt = (word_count + 8'd1 == n_reg) ? S_CSUM : S_B0;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (rx_data == csum) begin
            done_nxt  = 1'b1;
            hold_nxt  = 1'b0;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ERR;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // An arriving byte beats the timeout in the same cycle.
    if (active && !accept && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
      state_nxt = S_ERR;
      tmo_nxt   = '0;
    end

    if (state_nxt == S_ERR && state != S_ERR)
      error_nxt = 1'b1;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame parsing, checksum, range, timeout and async reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [10:0] imem_addr;
  logic [18:0] imem_wdata;
  logic        cpu_hold, done, error;
  logic [7:0]  word_count;

  logic        b_rx_ready, b_imem_we, b_cpu_hold, b_done, b_error;
  logic [10:0] b_imem_addr;
  logic [18:0] b_imem_wdata;
  logic [7:0]  b_word_count;

  int checks = 0;
  int failures = 0;

  logic [7:0]  q[$];
  logic [10:0] log_addr[32];
  logic [18:0] log_data[32];
  int          nwr = 0;
  int          pulse_err = 0;
  logic        prev_we = 1'b0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done),
    .error(error), .word_count(word_count)
  );

  imem_loader #(.BASE_ADDR(2046)) dut_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(b_rx_ready), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
    .imem_wdata(b_imem_wdata), .cpu_hold(b_cpu_hold), .done(b_done),
    .error(b_error), .word_count(b_word_count)
  );

  always @(negedge clk) begin
    if (imem_we) begin
      if (nwr < 32) begin
        log_addr[nwr] = imem_addr;
        log_data[nwr] = imem_wdata;
      end
      nwr++;
      if (prev_we) pulse_err++;
    end
    prev_we = imem_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_q();
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rx_data  = q[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check("rst_ready", rx_ready, 1);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_wc", word_count, 0);
    reset = 1'b0;
    idle(2);

    // Good 2-word frame; checksum 02^07^FF^FF^00^00^01 = 04
    q = '{8'hA5, 8'h02, 8'h07, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h04};
    send_q();
    idle(2);
    check("good_nwr", nwr, 2);
    check("good_a0", log_addr[0], 0);
    check("good_d0", log_data[0], 19'h7FFFF);
    check("good_a1", log_addr[1], 1);
    check("good_d1", log_data[1], 19'h00001);
    check("good_done", done, 1);
    check("good_hold", cpu_hold, 0);
    check("good_wc", word_count, 2);
    check("good_err", error, 0);

    // Same frame, bad checksum
    q = '{8'hA5, 8'h02, 8'h07, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00};
    send_q();
    idle(2);
    check("badcs_nwr", nwr, 4);
    check("badcs_err", error, 1);
    check("badcs_hold", cpu_hold, 1);
    check("badcs_done", done, 0);

    q = '{8'hA5, 8'h02, 8'h07, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h04};
    send_q();
    idle(2);
    check("recover_err", error, 0);
    check("recover_done", done, 1);
    check("recover_nwr", nwr, 6);

    // Garbage before header
    q = '{8'h11, 8'h22, 8'h33, 8'hA5, 8'h01, 8'h00, 8'h12, 8'h34, 8'h27};
    send_q();
    idle(2);
    check("garb_nwr", nwr, 7);
    check("garb_a", log_addr[6], 0);
    check("garb_d", log_data[6], 19'h01234);
    check("garb_done", done, 1);
    check("garb_wc", word_count, 1);

    // B0 with upper bits set
    q = '{8'hA5, 8'h01, 8'h08};
    send_q();
    idle(2);
    check("b0hi_err", error, 1);
    check("b0hi_nwr", nwr, 7);

    // Zero count
    q = '{8'hA5, 8'h00};
    send_q();
    idle(2);
    check("n0_err", error, 1);
    check("n0_done", done, 0);

    // N=3 overflows BASE_ADDR=2046 on dut_b; dut accepts it and then stalls
    q = '{8'hA5, 8'h03, 8'h00, 8'h12};
    send_q();
    check("range_err_b", b_error, 1);
    check("tmo_pre_err", error, 0);
    n = 0;
    while (!error && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("tmo_cycles", n, 1000);
    check("tmo_nwr", nwr, 7);

    // Reset during B1 of second word
    q = '{8'hA5, 8'h02, 8'h07, 8'hFF, 8'hFF, 8'h00};
    send_q();
    check("mid_wc", word_count, 1);
    check("mid_addr", imem_addr, 1);
    reset = 1'b1;
    #1;
    check("arst_addr", imem_addr, 0);
    check("arst_wc", word_count, 0);
    check("arst_wdata", imem_wdata, 0);
    check("arst_we", imem_we, 0);
    check("arst_hold", cpu_hold, 1);
    check("arst_err", error, 0);
    check("arst_done", done, 0);
    idle(2);
    reset = 1'b0;
    idle(1);

    q = '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h34, 8'h27};
    send_q();
    idle(2);
    check("post_nwr", nwr, 9);
    check("post_a", log_addr[8], 0);
    check("post_d", log_data[8], 19'h01234);
    check("post_done", done, 1);
    check("post_hold", cpu_hold, 0);
    check("we_pulse", pulse_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
